// File: rtl/pwm_capture_pkg.sv
// Shared types and defaults for the PWM capture block.
package pwm_capture_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      HIGH,
      LOW
   } capture_state_t;

   localparam int DEFAULT_DATA_WIDTH = 32;

endpackage

// File: rtl/pwm_capture_in_cond.sv
// Input conditioning: synchronizer, optional glitch filter, edge pulses.
// Define GLITCH_FILTER_EN to require FILTER_LEN stable clocks before s follows the input.
module pwm_in_cond
   import pwm_capture_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic pwm_in,
   output logic s,
   output logic rise,
   output logic fall
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("pwm_in_cond: SYNC_STAGES must be at least 2");
   end
   if (FILTER_LEN < 1) begin : g_bad_filter
      $error("pwm_in_cond: FILTER_LEN must be at least 1");
   end

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   s_prev_q, s_prev_d;

`ifdef GLITCH_FILTER_EN
   localparam int STAB_W = $clog2(FILTER_LEN + 1);

   logic              filt_q, filt_d;
   logic [STAB_W-1:0] stab_q, stab_d;

   // Any return to the current level restarts the stability count.
   always_comb begin
      filt_d = filt_q;
      stab_d = '0;
      if (sync_q[SYNC_STAGES-1] != filt_q) begin
         if (stab_q == STAB_W'(FILTER_LEN - 1)) filt_d = sync_q[SYNC_STAGES-1];
         else                                   stab_d = stab_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         filt_q <= 1'b0;
         stab_q <= '0;
      end else begin
         filt_q <= filt_d;
         stab_q <= stab_d;
      end
   end

   assign s = filt_q;
`else
   assign s = sync_q[SYNC_STAGES-1];
`endif

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_prev_d = s;
   end

   // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= '0;
         s_prev_q <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         s_prev_q <= s_prev_d;
      end
   end

   assign rise = s & ~s_prev_q;
   assign fall = ~s & s_prev_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of each complete cycle on pwm_in,
// with valid/ready output, overrun and stuck-line flags. Optional: GLITCH_FILTER_EN.
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int FILTER_LEN     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  pwm_in,
   input  logic                  meas_ready,
   input  logic                  ovr_clr,
   output logic                  meas_valid,
   output logic [DATA_WIDTH-1:0] period_cnt,
   output logic [DATA_WIDTH-1:0] high_cnt,
   output logic                  overrun,
   output logic                  stuck_high,
   output logic                  stuck_low
);

   if (TIMEOUT_CYCLES < 1 || (DATA_WIDTH < 31 && TIMEOUT_CYCLES >= (1 << DATA_WIDTH))) begin : g_bad_timeout
      $error("pwm_capture: TIMEOUT_CYCLES must be in 1 .. 2**DATA_WIDTH-1");
   end

   localparam logic [DATA_WIDTH-1:0] TIMEOUT_LIM = DATA_WIDTH'(TIMEOUT_CYCLES);

   logic s, rise, fall;

   pwm_in_cond #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_in_cond (
      .clk    (clk),
      .rst    (rst),
      .pwm_in (pwm_in),
      .s      (s),
      .rise   (rise),
      .fall   (fall)
   );

   capture_state_t        state_q, state_d;
   logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] high_tmp_q, high_tmp_d;
   logic [DATA_WIDTH-1:0] period_q, period_d;
   logic [DATA_WIDTH-1:0] high_q, high_d;
   logic                  valid_q, valid_d;
   logic                  overrun_q, overrun_d;
   logic                  stuck_high_q, stuck_high_d;
   logic                  stuck_low_q, stuck_low_d;
   logic                  complete, timeout;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      high_tmp_d   = high_tmp_q;
      period_d     = period_q;
      high_d       = high_q;
      valid_d      = valid_q & ~meas_ready;
      overrun_d    = overrun_q & ~ovr_clr;
      stuck_high_d = stuck_high_q & ~(rise | fall);
      stuck_low_d  = stuck_low_q & ~(rise | fall);
      complete     = 1'b0;
      timeout      = 1'b0;

      if (rise)                 cnt_d = DATA_WIDTH'(1);
      else if (cnt_q != '1)     cnt_d = cnt_q + 1'b1;
      else                      cnt_d = cnt_q;

      if (!en) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         timeout = (state_q != IDLE) && !rise && !fall && (cnt_q == TIMEOUT_LIM);
         unique case (state_q)
            IDLE: state_d = ARM;
            ARM:  if (rise) state_d = HIGH;
            HIGH: if (fall) begin
               high_tmp_d = cnt_q;
               state_d    = LOW;
            end
            LOW:  if (rise) begin
               complete = 1'b1;
               state_d  = HIGH;
            end
            default: state_d = IDLE;
         endcase
         // A stuck line restarts the timeout window and rearms for a fresh first cycle.
         if (timeout) begin
            state_d = ARM;
            cnt_d   = '0;
            if (s) stuck_high_d = 1'b1;
            else   stuck_low_d  = 1'b1;
         end
      end

      if (complete) begin
         if (!valid_q || meas_ready) begin
            period_d = cnt_q;
            high_d   = high_tmp_q;
            valid_d  = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         high_tmp_q   <= '0;
         period_q     <= '0;
         high_q       <= '0;
         valid_q      <= 1'b0;
         overrun_q    <= 1'b0;
         stuck_high_q <= 1'b0;
         stuck_low_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         high_tmp_q   <= high_tmp_d;
         period_q     <= period_d;
         high_q       <= high_d;
         valid_q      <= valid_d;
         overrun_q    <= overrun_d;
         stuck_high_q <= stuck_high_d;
         stuck_low_q  <= stuck_low_d;
      end
   end

   assign meas_valid = valid_q;
   assign period_cnt = period_q;
   assign high_cnt   = high_q;
   assign overrun    = overrun_q;
   assign stuck_high = stuck_high_q;
   assign stuck_low  = stuck_low_q;

endmodule
